alu_seq: RTL and testbench

- Parametrised, handshaked successor to the datapath ALU.
- Single-cycle logic/arithmetic/shift ops complete with a one-cycle registered result.
- Multiply and (optionally) divide run as iterative multi-cycle operations.
- Sits between register-read and writeback; the pipeline controller stalls on `in_ready`.
- `zero` is a true "result == 0" flag, registered with the result.

---
 rtl/alu_seq.sv | 269 ++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; 1-cycle logic/arith/shift, iterative mul and div/rem.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise div/rem are illegal opcodes.
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ovf,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef ALU_SEQ_DIV_EN
  localparam int AW = WIDTH + 1;
`else
  localparam int AW = WIDTH;
`endif

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_REM  = 4'b1011;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef ALU_SEQ_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  c_q, c_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              ov_q, ov_d;

  logic [SHW-1:0]    sh;
  logic [WIDTH-1:0]  sum, dif, alu_r, mul_a, done_r;
  logic              alu_ovf, alu_err, is_mul, done_e;

`ifdef ALU_SEQ_DIV_EN
  logic              isdiv_q, isdiv_d;
  logic              isrem_q, isrem_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;
  logic              is_div;
  logic [AW-1:0]     shl, sub, div_a;
  logic [WIDTH-1:0]  div_c;

  // Restoring step: sub[WIDTH] set means the trial subtraction went negative
  assign shl   = {a_q[WIDTH-1:0], c_q[WIDTH-1]};
  assign sub   = shl - {1'b0, b_q};
  assign div_a = sub[WIDTH] ? shl : sub;
  assign div_c = {c_q[WIDTH-2:0], ~sub[WIDTH]};
`endif

  assign sh    = in2[SHW-1:0];
  assign sum   = in1 + in2;
  assign dif   = in1 - in2;
  assign mul_a = a_q[WIDTH-1:0] + (c_q[0] ? b_q : '0);

  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    is_div  = 1'b0;
`endif
    unique case (ALUControl)
      OP_ADD: begin
        alu_r   = sum;
        alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r   = dif;
        alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  alu_r = in1 & in2;
      OP_OR:   alu_r = in1 | in2;
      OP_NOR:  alu_r = ~(in1 | in2);
      OP_XOR:  alu_r = in1 ^ in2;
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: alu_r = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_SLL:  alu_r = in1 << sh;
      OP_SRL:  alu_r = in1 >> sh;
      OP_SRA:  alu_r = $signed(in1) >>> sh;
      OP_MUL:  is_mul = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      OP_DIV, OP_REM: is_div = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    ov_d    = ov_q && !out_ready;
    done_r  = mul_a;
    done_e  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    isdiv_d = isdiv_q;
    isrem_d = isrem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    // DONE retires the final step, so sign fix-up works on the step outputs
    if (isdiv_q) begin
      if (isrem_q)
        done_r = rneg_q ? -div_a[WIDTH-1:0] : div_a[WIDTH-1:0];
      else if (dz_q)
        done_r = '1;
      else
        done_r = qneg_q ? -div_c : div_c;
      done_e = dz_q;
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (is_mul) begin
            state_d = MUL;
            cnt_d   = CW'(WIDTH);
            a_d     = '0;
            b_d     = in1;
            c_d     = in2;
`ifdef ALU_SEQ_DIV_EN
            isdiv_d = 1'b0;
`endif
          end
`ifdef ALU_SEQ_DIV_EN
          else if (is_div) begin
            state_d = DIV;
            cnt_d   = CW'(WIDTH);
            a_d     = '0;
            b_d     = in2[WIDTH-1] ? -in2 : in2;
            c_d     = in1[WIDTH-1] ? -in1 : in1;
            isdiv_d = 1'b1;
            isrem_d = (ALUControl == OP_REM);
            qneg_d  = in1[WIDTH-1] ^ in2[WIDTH-1];
            rneg_d  = in1[WIDTH-1];
            dz_d    = (in2 == '0);
          end
`endif
          else begin
            res_d  = alu_r;
            zero_d = (alu_r == '0);
            ovf_d  = alu_ovf;
            err_d  = alu_err;
            ov_d   = 1'b1;
          end
        end
      end
      MUL: begin
        a_d   = AW'(mul_a);
        b_d   = b_q << 1;
        c_d   = c_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(2)) state_d = DONE;
      end
`ifdef ALU_SEQ_DIV_EN
      DIV: begin
        a_d   = div_a;
        c_d   = div_c;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(2)) state_d = DONE;
      end
`endif
      DONE: begin
        res_d   = done_r;
        zero_d  = (done_r == '0);
        ovf_d   = 1'b0;
        err_d   = done_e;
        ov_d    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      isdiv_q <= 1'b0;
      isrem_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
`ifdef ALU_SEQ_DIV_EN
      isdiv_q <= isdiv_d;
      isrem_q <= isrem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && (!ov_q || out_ready);
  assign out_valid = ov_q;
  assign res       = res_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=32.
// Honours ALU_SEQ_DIV_EN to pick div/rem expectations.
module tb_alu_seq;

  localparam int W = 32;

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND = 4'b0000;
  localparam logic [3:0] OR_ = 4'b0001, NOR = 4'b1100, XOR = 4'b0011;
  localparam logic [3:0] SLT = 4'b0111, SLTU = 4'b1000, SLL = 4'b0100;
  localparam logic [3:0] SRL = 4'b0101, SRA = 4'b1101, MUL = 4'b1001;
  localparam logic [3:0] DIV = 4'b1010, REM = 4'b1011, BAD = 4'b1111;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1, in2;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         zero, ovf, err, busy;

  typedef struct {
    logic [W-1:0] r;
    logic         z, o, e;
    int           lat;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    exp_t         x;
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .ALUControl(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .zero(zero), .ovf(ovf), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [3:0] o, logic [W-1:0] a, logic [W-1:0] b,
                              logic [W-1:0] r, logic z, logic ov, logic e, int lat);
    vec_t v;
    v.op = o; v.a = a; v.b = b;
    v.x.r = r; v.x.z = z; v.x.o = ov; v.x.e = e; v.x.lat = lat;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it until the accepting edge has passed.
  task automatic drive_op(input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, output bit acc);
    int n;
    acc = 1'b0;
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    n = 0;
    while (n < 100 && !in_ready) begin step(); n++; end
    if (in_ready) begin step(); acc = 1'b1; end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 1;
    while (lat < 100 && !out_valid) begin step(); lat++; end
    ok = out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = ADD; in1 = '0; in2 = '0;
    step(); step();
    reset = 1'b0;
    checks++;
    if (res !== '0 || zero !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        busy !== 1'b0 || ovf !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: res=%h zero=%b ov=%b rdy=%b busy=%b ovf=%b err=%b, required 0 1 0 1 0 0 0",
               res, zero, out_valid, in_ready, busy, ovf, err);
    end
  endtask

  task automatic test_single();
    vec_t v[$];
    exp_t x;
    bit acc, ok;
    int lat;
    logic [W-1:0] a, b, s;
    v.push_back(mk(ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 0, 1));
    v.push_back(mk(SUB, 32'd5, 32'd5, 32'h0, 1, 0, 0, 1));
    v.push_back(mk(SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1, 0, 1));
    v.push_back(mk(ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 0, 1));
    v.push_back(mk(AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 0, 1));
    v.push_back(mk(OR_, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 0, 0, 0, 1));
    v.push_back(mk(NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 1));
    v.push_back(mk(XOR, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 0, 0, 0, 1));
    v.push_back(mk(SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 0, 1));
    v.push_back(mk(SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 0, 1));
    v.push_back(mk(SLL, 32'h1, 32'h21, 32'h2, 0, 0, 0, 1));
    v.push_back(mk(SRL, 32'h8000_0000, 32'h4, 32'h0800_0000, 0, 0, 0, 1));
    v.push_back(mk(SRA, 32'h8000_0000, 32'h4, 32'hF800_0000, 0, 0, 0, 1));
    v.push_back(mk(BAD, 32'h1234, 32'h5678, 32'h0, 1, 0, 1, 1));
    for (int k = 0; k < 6; k++) begin
      a = $urandom; b = $urandom;
      s = a + b;
      v.push_back(mk(ADD, a, b, s, s == 0,
                     (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]), 0, 1));
    end
    foreach (v[i]) begin
      sb.push_back(v[i].x);
      drive_op(v[i].op, v[i].a, v[i].b, acc);
      wait_out(lat, ok);
      x = sb.pop_front();
      checks++;
      if (!acc || !ok) begin
        errors++;
        $display("FAIL single[%0d] timeout: acc=%0b out=%0b, required 1 1", i, acc, ok);
      end else if ({res, zero, ovf, err} !== {x.r, x.z, x.o, x.e}) begin
        errors++;
        $display("FAIL single[%0d] op=%b: res=%h z=%b o=%b e=%b, required %h %b %b %b",
                 i, v[i].op, res, zero, ovf, err, x.r, x.z, x.o, x.e);
      end
      checks++;
      if (lat !== x.lat) begin
        errors++;
        $display("FAIL single[%0d] latency: %0d, required %0d", i, lat, x.lat);
      end
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    exp_t x;
    bit acc, bad;
    int lat;
    v.push_back(mk(MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 0, 0, 0, W + 1));
    v.push_back(mk(MUL, 32'd12345, 32'd6789, 32'd83810205, 0, 0, 0, W + 1));
    v.push_back(mk(MUL, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd6, 0, 0, 0, W + 1));
    v.push_back(mk(MUL, 32'h0, 32'hDEAD_BEEF, 32'h0, 1, 0, 0, W + 1));
    foreach (v[i]) begin
      sb.push_back(v[i].x);
      drive_op(v[i].op, v[i].a, v[i].b, acc);
      lat = 1; bad = 1'b0;
      while (lat < 100 && !out_valid) begin
        if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        // Stray requests mid-op must be ignored
        if (lat >= 5 && lat < 9) begin
          in_valid = 1'b1; op = ADD; in1 = 32'h1; in2 = 32'h1;
        end else begin
          in_valid = 1'b0;
        end
        step();
        lat++;
      end
      in_valid = 1'b0;
      x = sb.pop_front();
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL mul[%0d] busy/in_ready during op, required busy=1 in_ready=0", i);
      end
      checks++;
      if (!acc || !out_valid) begin
        errors++;
        $display("FAIL mul[%0d] timeout: acc=%0b out=%0b, required 1 1", i, acc, out_valid);
      end else if ({res, zero, ovf, err} !== {x.r, x.z, x.o, x.e}) begin
        errors++;
        $display("FAIL mul[%0d]: res=%h z=%b o=%b e=%b, required %h %b %b %b",
                 i, res, zero, ovf, err, x.r, x.z, x.o, x.e);
      end
      checks++;
      if (lat !== x.lat) begin
        errors++;
        $display("FAIL mul[%0d] latency: %0d, required %0d", i, lat, x.lat);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mul[%0d] stray result: out_valid=%b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[$];
    exp_t x;
    bit acc, ok;
    int lat;
`ifdef ALU_SEQ_DIV_EN
    v.push_back(mk(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0, 0, W + 1));
    v.push_back(mk(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0, 0, W + 1));
    v.push_back(mk(DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 0, 0, 1, W + 1));
    v.push_back(mk(REM, 32'd9, 32'd0, 32'd9, 0, 0, 1, W + 1));
    v.push_back(mk(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, W + 1));
    v.push_back(mk(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, W + 1));
    v.push_back(mk(DIV, 32'd100, 32'd7, 32'd14, 0, 0, 0, W + 1));
    v.push_back(mk(REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, W + 1));
`else
    v.push_back(mk(DIV, 32'd9, 32'd2, 32'h0, 1, 0, 1, 1));
    v.push_back(mk(REM, 32'd9, 32'd2, 32'h0, 1, 0, 1, 1));
`endif
    foreach (v[i]) begin
      sb.push_back(v[i].x);
      drive_op(v[i].op, v[i].a, v[i].b, acc);
      wait_out(lat, ok);
      x = sb.pop_front();
      checks++;
      if (!acc || !ok) begin
        errors++;
        $display("FAIL div[%0d] timeout: acc=%0b out=%0b, required 1 1", i, acc, ok);
      end else if ({res, zero, ovf, err} !== {x.r, x.z, x.o, x.e}) begin
        errors++;
        $display("FAIL div[%0d] op=%b: res=%h z=%b o=%b e=%b, required %h %b %b %b",
                 i, v[i].op, res, zero, ovf, err, x.r, x.z, x.o, x.e);
      end
      checks++;
      if (lat !== x.lat) begin
        errors++;
        $display("FAIL div[%0d] latency: %0d, required %0d", i, lat, x.lat);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    bit acc, seen;
    drive_op(MUL, 32'h1234_5678, 32'h9ABC_DEF0, acc);
    for (int k = 0; k < 9; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (!acc || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || res !== '0) begin
      errors++;
      $display("FAIL mid_mul_reset: acc=%0b rdy=%b busy=%b ov=%b res=%h, required 1 1 0 0 0",
               acc, in_ready, busy, out_valid, res);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_mul_reset: out_valid=1 after abort, required 0");
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    bit acc, ok;
    int lat;
    out_ready = 1'b0;
    x.r = 32'd7; x.z = 1'b0; x.o = 1'b0; x.e = 1'b0; x.lat = 1;
    sb.push_back(x);
    drive_op(ADD, 32'd3, 32'd4, acc);
    wait_out(lat, ok);
    x = sb.pop_front();
    checks++;
    if (!acc || !ok || res !== x.r || lat !== x.lat) begin
      errors++;
      $display("FAIL bp_first: acc=%0b ok=%0b res=%h lat=%0d, required 1 1 %h %0d",
               acc, ok, res, lat, x.r, x.lat);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || res !== x.r || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ov=%b res=%h rdy=%b, required 1 %h 0",
                 k, out_valid, res, in_ready, x.r);
      end
    end
    x.r = 32'h0000_00F0; x.z = 1'b0; x.o = 1'b0; x.e = 1'b0; x.lat = 1;
    sb.push_back(x);
    in_valid = 1'b1; op = XOR; in1 = 32'hFF; in2 = 32'h0F;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    x = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || res !== x.r || zero !== x.z || err !== x.e) begin
      errors++;
      $display("FAIL b2b_result: ov=%b res=%h z=%b e=%b, required 1 %h %b %b",
               out_valid, res, zero, err, x.r, x.z, x.e);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_reset_mid_mul();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
